// File: rtl/anneal_sequencer_pkg.sv
// anneal_sequencer_pkg: shared types, timing constants and helpers for the iteration sequencer
package anneal_sequencer_pkg;
  localparam int DIST_CYC = 8;
  localparam int MET_CYC  = 3;
  localparam int ORD_CYC  = 4;
  localparam int REP_CYC  = 4;
  localparam int ITER_W   = 32;
  localparam int TMR_W    = 8;
  typedef enum logic {DIST_IDLE, DIST_RUN} distance_command_t;
  typedef enum logic [1:0] {EX_NOP, EX_EVEN, EX_ODD} exchange_command_t;
  typedef enum logic [1:0] {OPT_FIRST, OPT_SWAP, OPT_REVERSE, OPT_LAST} opt_command_t;
  typedef enum logic [3:0] {
    ST_IDLE, ST_SEED, ST_RAND, ST_DIST, ST_METRO, ST_ORD, ST_REPL, ST_SHIFT, ST_BOUND, ST_DONE
  } seq_state_t;
  function automatic opt_command_t opt_next(input opt_command_t o);
    return (o == OPT_LAST) ? OPT_FIRST : opt_command_t'(o + 2'd1);
  endfunction
endpackage

// File: rtl/anneal_sequencer_if.sv
// anneal_sequencer_if: host controls and node-chain broadcast controls of the sequencer
interface anneal_sequencer_if;
  import anneal_sequencer_pkg::*;
  logic                start;
  logic                abort;
  logic [63:0]         seed;
  logic [ITER_W-1:0]   run_times;
  logic [7:0]          ex_period;
  logic                busy;
  logic                done;
  logic [ITER_W-1:0]   iter_count;
  logic                random_init;
  logic [63:0]         random_seed;
  logic                random_run;
  opt_command_t        opt_command;
  distance_command_t   distance_com;
  logic                metropolis_run;
  logic                exchange_valid;
  logic                rbank;
  logic                shift_distance;
  logic                replica_run;
  logic                exchange_run;
  exchange_command_t   c_exchange;
  modport master (
    output start, abort, seed, run_times, ex_period,
    input  busy, done, iter_count, random_init, random_seed, random_run, opt_command, distance_com,
           metropolis_run, exchange_valid, rbank, shift_distance, replica_run, exchange_run, c_exchange
  );
  modport slave (
    input  start, abort, seed, run_times, ex_period,
    output busy, done, iter_count, random_init, random_seed, random_run, opt_command, distance_com,
           metropolis_run, exchange_valid, rbank, shift_distance, replica_run, exchange_run, c_exchange
  );
endinterface

// File: rtl/anneal_sequencer_seq_timer.sv
// anneal_sequencer_seq_timer: loadable down-counter that parks at zero, shared by all wait states
module anneal_sequencer_seq_timer
  import anneal_sequencer_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             load_i,
  input  logic [TMR_W-1:0] load_val_i,
  output logic             zero_o
);
  logic [TMR_W-1:0] count_q, count_d;
  assign zero_o = count_q == '0;
  always_comb count_d = load_i ? load_val_i : (zero_o ? count_q : count_q - TMR_W'(1));
  always_ff @(posedge clk) begin
    if (reset) count_q <= '0;
    else count_q <= count_d;
  end
endmodule

// File: rtl/anneal_sequencer.sv
// anneal_sequencer: per-iteration broadcast control sequencer for the replica-exchange node array
module anneal_sequencer
  import anneal_sequencer_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  anneal_sequencer_if.slave bus_if
);
  seq_state_t        state_q;
  logic [ITER_W-1:0] iter_q, iter_d, run_q;
  logic [7:0]        ex_period_q, ex_cnt_q;
  logic [63:0]       seed_q;
  logic              parity_q, busy_q, done_q, init_q, run_pulse_q, metro_q, exv_q, rbank_q;
  logic              shift_q, repl_q, exrun_q;
  opt_command_t      opt_q;
  distance_command_t dist_q;
  exchange_command_t cex_q;
  logic              due, tmr_load, tmr_zero;
  logic [TMR_W-1:0]  tmr_val;
  // ex_cnt_q tracks iter_count mod ex_period, so the exchange test needs no divider
  always_comb begin
    iter_d   = &iter_q ? iter_q : iter_q + 1'b1;
    due      = ex_period_q != '0 && ex_cnt_q == ex_period_q - 8'd1;
    tmr_load = state_q == ST_RAND ||
               (tmr_zero && (state_q == ST_DIST || state_q == ST_METRO || (state_q == ST_ORD && due)));
    tmr_val  = state_q == ST_RAND  ? TMR_W'(DIST_CYC - 1) :
               state_q == ST_DIST  ? TMR_W'(MET_CYC) :
               state_q == ST_METRO ? TMR_W'(ORD_CYC - 1) : TMR_W'(REP_CYC);
  end
  anneal_sequencer_seq_timer u_timer (
    .clk(clk), .reset(reset), .load_i(tmr_load), .load_val_i(tmr_val), .zero_o(tmr_zero)
  );
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE; iter_q <= '0; run_q <= '0; ex_period_q <= '0; ex_cnt_q <= '0;
      seed_q <= '0; parity_q <= 1'b0; busy_q <= 1'b0; done_q <= 1'b0; init_q <= 1'b0;
      run_pulse_q <= 1'b0; metro_q <= 1'b0; exv_q <= 1'b0; rbank_q <= 1'b0; shift_q <= 1'b0;
      repl_q <= 1'b0; exrun_q <= 1'b0; opt_q <= OPT_FIRST; dist_q <= DIST_IDLE; cex_q <= EX_NOP;
    end else begin
      done_q <= 1'b0; init_q <= 1'b0; run_pulse_q <= 1'b0; metro_q <= 1'b0;
      shift_q <= 1'b0; repl_q <= 1'b0;
      case (state_q)
        ST_IDLE: if (bus_if.start) begin
          state_q <= ST_SEED; busy_q <= 1'b1; init_q <= 1'b1; seed_q <= bus_if.seed;
          run_q <= bus_if.run_times; ex_period_q <= bus_if.ex_period; iter_q <= '0; ex_cnt_q <= '0;
        end
        ST_SEED: if (run_q == '0) begin
          state_q <= ST_DONE; done_q <= 1'b1;
        end else begin
          state_q <= ST_RAND; run_pulse_q <= 1'b1;
        end
        ST_RAND: begin
          state_q <= ST_DIST; dist_q <= DIST_RUN;
        end
        ST_DIST: if (tmr_zero) begin
          state_q <= ST_METRO; dist_q <= DIST_IDLE; metro_q <= 1'b1;
        end
        ST_METRO: if (tmr_zero) begin
          state_q <= ST_ORD; exv_q <= 1'b1;
        end
        ST_ORD: if (tmr_zero) begin
          exv_q <= 1'b0; rbank_q <= ~rbank_q;
          state_q <= due ? ST_REPL : ST_BOUND;
          repl_q <= due; exrun_q <= due;
          cex_q <= !due ? EX_NOP : parity_q ? EX_ODD : EX_EVEN;
        end
        ST_REPL: if (tmr_zero) begin
          state_q <= ST_SHIFT; shift_q <= 1'b1; exrun_q <= 1'b0; cex_q <= EX_NOP; parity_q <= ~parity_q;
        end
        ST_SHIFT: state_q <= ST_BOUND;
        ST_BOUND: begin
          iter_q <= iter_d; opt_q <= opt_next(opt_q);
          ex_cnt_q <= (ex_cnt_q == ex_period_q - 8'd1) ? '0 : ex_cnt_q + 8'd1;
          // abort is honoured only here, so nodes never see a half-finished iteration
          if (iter_d == run_q || bus_if.abort) begin
            state_q <= ST_DONE; done_q <= 1'b1;
          end else begin
            state_q <= ST_RAND; run_pulse_q <= 1'b1;
          end
        end
        ST_DONE: begin
          state_q <= ST_IDLE; busy_q <= 1'b0;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end
  assign bus_if.busy           = busy_q;
  assign bus_if.done           = done_q;
  assign bus_if.iter_count     = iter_q;
  assign bus_if.random_init    = init_q;
  assign bus_if.random_seed    = seed_q;
  assign bus_if.random_run     = run_pulse_q;
  assign bus_if.opt_command    = opt_q;
  assign bus_if.distance_com   = dist_q;
  assign bus_if.metropolis_run = metro_q;
  assign bus_if.exchange_valid = exv_q;
  assign bus_if.rbank          = rbank_q;
  assign bus_if.shift_distance = shift_q;
  assign bus_if.replica_run    = repl_q;
  assign bus_if.exchange_run   = exrun_q;
  assign bus_if.c_exchange     = cex_q;
endmodule
